irq_vector_ctrl: RTL and testbench

IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

---
 rtl/irq_vector_ctrl_if.sv | 27 ++
 rtl/irq_vector_ctrl.sv | 123 ++++++++++++
 tb/tb_irq_vector_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_vector_ctrl_if.sv
// Avalon-MM register port of the interrupt vector controller.
// Handshake: no waitrequest. A write is accepted on every rising edge where
// chipselect && !write_n; readdata is registered and reflects the address
// presented in the previous cycle, whether or not chipselect was high.
interface irq_vector_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Interrupt latch/mask/vector controller with an edge event counter.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on irq_in.
module irq_vector_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_vector_ctrl_if.slave   bus,
  input  logic [N_IRQ-1:0]   irq_in,
  output logic               irq_out
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_FORCE   = 3'd4;
  localparam logic [2:0] ADDR_EVCOUNT = 3'd5;

  // Bits at and above N_IRQ are held at zero everywhere through this mask.
  localparam logic [15:0] IMPL = 16'((32'd1 << N_IRQ) - 32'd1);

  logic [15:0] irq_raw;
  logic [15:0] irq_s;
  logic [15:0] irq_d;
  logic [15:0] latch_q;
  logic [15:0] mask_q;
  logic [15:0] mode_q;
  logic [15:0] evcount_q;
  logic [15:0] pending;
  logic [15:0] masked;
  logic [15:0] rise;
  logic [15:0] latch_set;
  logic [15:0] latch_clr;
  logic [15:0] vector;
  logic [15:0] rd_next;
  logic [3:0]  vec_idx;
  logic        wr_stb;
  logic        edge_any;

  assign irq_raw = 16'(irq_in) & IMPL;

`ifdef IRQ_SYNC_EN
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_raw;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_raw;
`endif

  assign wr_stb    = bus.chipselect && !bus.write_n;
  assign rise      = irq_s & ~irq_d;
  // Level sources feed pending directly, so W1C cannot hide a held line.
  assign pending   = latch_q | (irq_s & ~mode_q);
  assign masked    = pending & mask_q;
  assign edge_any  = |(rise & mode_q);

  assign latch_set = ((rise & mode_q) |
                      ((wr_stb && bus.address == ADDR_FORCE) ? bus.writedata : 16'd0)) & IMPL;
  assign latch_clr = (wr_stb && bus.address == ADDR_PENDING) ? bus.writedata : 16'd0;

  always_comb begin
    vec_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (masked[i]) vec_idx = 4'(i);
    end
  end

  assign vector = (|masked) ? {1'b1, 11'd0, vec_idx} : 16'd0;

  always_comb begin
    rd_next = 16'd0;
    case (bus.address)
      ADDR_PENDING: rd_next = pending;
      ADDR_MASK:    rd_next = mask_q;
      ADDR_MODE:    rd_next = mode_q;
      ADDR_VECTOR:  rd_next = vector;
      ADDR_EVCOUNT: rd_next = evcount_q;
      default:      rd_next = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_d        <= '0;
      latch_q      <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      irq_out      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      irq_d        <= irq_s;
      // Set is applied after clear so a coincident set wins.
      latch_q      <= (latch_q & ~latch_clr) | latch_set;
      if (wr_stb && bus.address == ADDR_MASK) mask_q <= bus.writedata & IMPL;
      if (wr_stb && bus.address == ADDR_MODE) mode_q <= bus.writedata & IMPL;
      irq_out      <= |masked;
      bus.readdata <= rd_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evcount_q <= '0;
    end else if (wr_stb && bus.address == ADDR_EVCOUNT) begin
      evcount_q <= '0;
    end else if (edge_any && evcount_q != 16'hFFFF) begin
      evcount_q <= evcount_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Randomised and directed bench for irq_vector_ctrl against a per-source
// behavioural model; define IRQ_SYNC_EN to match a synchronised build.
module tb_irq_vector_ctrl;
  localparam int N = 8;
`ifdef IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] irq_in;
  logic         irq_out;

  irq_vector_ctrl_if bus();

  irq_vector_ctrl #(.N_IRQ(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [15:0]  exp_q[$];
  logic         exp_irq;
  logic [N-1:0] cur_irq;

  bit m_latch[N];
  bit m_mask[N];
  bit m_mode[N];
  bit m_d[N];
  bit m_h1[N];
  bit m_h2[N];
  int m_cnt;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_latch[i] = 0; m_mask[i] = 0; m_mode[i] = 0;
      m_d[i] = 0; m_h1[i] = 0; m_h2[i] = 0;
    end
    m_cnt = 0;
    exp_irq = 1'b0;
  endtask

  // Predicts readdata/irq_out after the coming edge, then advances state.
  task automatic model_step(input bit cs, input bit wn, input logic [2:0] addr,
                            input logic [15:0] wd, input logic [N-1:0] irq);
    bit s[N];
    bit rise[N];
    bit pend[N];
    bit wr;
    bit ev;
    bit set_b;
    bit clr_b;
    int first;
    logic [15:0] rd;
    for (int i = 0; i < N; i++) begin
      s[i]    = (SYNC == 2) ? m_h2[i] : irq[i];
      rise[i] = s[i] && !m_d[i];
      pend[i] = m_latch[i] || (s[i] && !m_mode[i]);
    end
    first = -1;
    for (int i = 0; i < N; i++)
      if (pend[i] && m_mask[i] && first < 0) first = i;
    rd = 16'd0;
    case (addr)
      3'd0: for (int i = 0; i < N; i++) rd[i] = pend[i];
      3'd1: for (int i = 0; i < N; i++) rd[i] = m_mask[i];
      3'd2: for (int i = 0; i < N; i++) rd[i] = m_mode[i];
      3'd3: if (first >= 0) rd = 16'h8000 | 16'(first);
      3'd5: rd = 16'(m_cnt);
      default: rd = 16'd0;
    endcase
    exp_q.push_back(rd);
    exp_irq = (first >= 0);
    wr = cs && !wn;
    ev = 0;
    for (int i = 0; i < N; i++) begin
      set_b = (rise[i] && m_mode[i]) || (wr && addr == 3'd4 && wd[i]);
      clr_b = wr && addr == 3'd0 && wd[i];
      if (rise[i] && m_mode[i]) ev = 1;
      if (set_b) m_latch[i] = 1;
      else if (clr_b) m_latch[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (wr && addr == 3'd1) m_mask[i] = wd[i];
      if (wr && addr == 3'd2) m_mode[i] = wd[i];
    end
    if (wr && addr == 3'd5) m_cnt = 0;
    else if (ev && m_cnt < 65535) m_cnt++;
    m_h2 = m_h1;
    for (int i = 0; i < N; i++) m_h1[i] = irq[i];
    m_d = s;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit cs, input bit wn, input logic [2:0] addr, input logic [15:0] wd);
    logic [15:0] want;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = addr;
    bus.writedata  = wd;
    irq_in         = cur_irq;
    model_step(cs, wn, addr, wd, cur_irq);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check_val("readdata", bus.readdata, want);
    check_val("irq_out", {15'd0, irq_out}, {15'd0, exp_irq});
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] wd);
    step(1'b1, 1'b0, addr, wd);
  endtask

  task automatic rd(input logic [2:0] addr);
    step(1'b1, 1'b1, addr, 16'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 3'd0, 16'd0);
  endtask

  task automatic settle();
    repeat (SYNC) idle();
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 16'd0;
    irq_in         = '0;
    cur_irq        = '0;
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_readdata", bus.readdata, 16'd0);
    check_val("reset_irq_out", {15'd0, irq_out}, 16'd0);
    reset_n = 1'b1;

    // Edge source pulse, latch, count and W1C.
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0001);
    cur_irq = 8'h01; idle(); cur_irq = 8'h00;
    check_val("edge_irq_early", {15'd0, irq_out}, 16'd0);
    settle();
    rd(3'd0);
    check_val("edge_pending", bus.readdata, 16'h0001);
    check_val("edge_irq_out", {15'd0, irq_out}, 16'd1);
    rd(3'd5);
    check_val("edge_evcount", bus.readdata, 16'h0001);
    wr(3'd0, 16'h0001);
    idle();
    check_val("edge_w1c_irq", {15'd0, irq_out}, 16'd0);

    // Held level source survives W1C.
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    cur_irq = 8'h04; idle(); settle();
    wr(3'd0, 16'h0004);
    rd(3'd0);
    check_val("level_pending", bus.readdata, 16'h0004);
    check_val("level_irq_on", {15'd0, irq_out}, 16'd1);
    cur_irq = 8'h00; idle(); settle();
    check_val("level_irq_off", {15'd0, irq_out}, 16'd0);

    // Vector priority via FORCE.
    wr(3'd1, 16'h00FF);
    wr(3'd4, 16'h0028);
    rd(3'd3); check_val("vector_3", bus.readdata, 16'h8003);
    wr(3'd0, 16'h0008);
    rd(3'd3); check_val("vector_5", bus.readdata, 16'h8005);
    wr(3'd0, 16'h0020);
    rd(3'd3); check_val("vector_none", bus.readdata, 16'h0000);
    rd(3'd4); check_val("force_reads_0", bus.readdata, 16'h0000);
    rd(3'd7); check_val("unmapped_7", bus.readdata, 16'h0000);

    // Set beats W1C in the same cycle.
    wr(3'd0, 16'hFFFF);
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    cur_irq = 8'h01; settle();
    wr(3'd0, 16'h0001);
    rd(3'd0);
    check_val("set_wins", {15'd0, bus.readdata[0]}, 16'd1);
    cur_irq = 8'h00; idle(); settle();

    // Counter saturation and clear-over-increment.
    force dut.evcount_q = 16'hFFFE;
    #1;
    release dut.evcount_q;
    m_cnt = 16'hFFFE;
    cur_irq = 8'h01; idle(); settle();
    cur_irq = 8'h00; idle(); settle();
    cur_irq = 8'h01; idle(); settle();
    rd(3'd5); check_val("evcount_sat", bus.readdata, 16'hFFFF);
    cur_irq = 8'h00; idle(); settle();
    cur_irq = 8'h01; settle();
    wr(3'd5, 16'h0000);
    rd(3'd5); check_val("evcount_clr", bus.readdata, 16'h0000);
    cur_irq = 8'h00; idle(); settle();

    // Asynchronous reset mid-operation.
    wr(3'd1, 16'h00FF);
    wr(3'd4, 16'h000F);
    rd(3'd0);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_readdata", bus.readdata, 16'h0000);
    check_val("async_rst_irq_out", {15'd0, irq_out}, 16'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic.
    repeat (800) begin
      int op;
      if ($urandom_range(0, 3) == 0) cur_irq = N'($urandom());
      op = $urandom_range(0, 3);
      case (op)
        0: step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 16'd0);
        1: rd(3'($urandom_range(0, 7)));
        default: wr(3'($urandom_range(0, 7)), 16'($urandom()));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
